// File: rtl/vx_socket_req_sched.sv
// ---------------------------------------------------------------------------
// vx_socket_req_sched
//
// Socket-level scheduler that shares a single cache request port among
// NUM_INPUTS cores. Requests are arbitrated round-robin. Each core may have
// at most MAX_PENDING reads outstanding. The winning core's index is appended
// in the LSBs of the outgoing tag, and responses are steered back to the core
// named by those LSBs.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   in_req_*  (per core)       valid/rw/addr/data/tag in, ready out (one-hot)
//   out_req_* (shared)         registered request towards the cache
//   rsp_*     (shared)         cache response in; rsp_ready back to cache
//   in_rsp_*  (per core)       one-hot valid, broadcast data/tag, ready in
//   busy                       request held or any read still outstanding
//   rsp_err                    sticky: response to an idle or nonexistent core
// ---------------------------------------------------------------------------
module vx_socket_req_sched #(
  parameter int NUM_INPUTS  = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 4,
  parameter int SEL_BITS    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  parameter int OTAG_W      = TAG_WIDTH + SEL_BITS
) (
  input  logic                             clk,
  input  logic                             reset,

  input  logic [NUM_INPUTS-1:0]            in_req_valid,
  input  logic [NUM_INPUTS-1:0]            in_req_rw,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0] in_req_addr,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_req_data,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0]  in_req_tag,
  output logic [NUM_INPUTS-1:0]            in_req_ready,

  output logic                             out_req_valid,
  output logic                             out_req_rw,
  output logic [ADDR_WIDTH-1:0]            out_req_addr,
  output logic [DATA_WIDTH-1:0]            out_req_data,
  output logic [OTAG_W-1:0]                out_req_tag,
  input  logic                             out_req_ready,

  input  logic                             rsp_valid,
  input  logic [DATA_WIDTH-1:0]            rsp_data,
  input  logic [OTAG_W-1:0]                rsp_tag,
  output logic                             rsp_ready,

  output logic [NUM_INPUTS-1:0]            in_rsp_valid,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] in_rsp_data,
  output logic [NUM_INPUTS*TAG_WIDTH-1:0]  in_rsp_tag,
  input  logic [NUM_INPUTS-1:0]            in_rsp_ready,

  output logic                             busy,
  output logic                             rsp_err
);

  // Counter just wide enough to hold MAX_PENDING.
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [NUM_INPUTS-1:0] eligible;
  logic [NUM_INPUTS-1:0] pend_zero;
  logic [NUM_INPUTS-1:0] pend_inc;
  logic [NUM_INPUTS-1:0] pend_dec;
  logic [CNT_W-1:0]      pend [NUM_INPUTS];

  logic [SEL_BITS-1:0]   rr_ptr;
  logic [SEL_BITS-1:0]   win_idx;
  logic [SEL_BITS:0]     cand;
  logic                  win_found;
  logic                  accept;

  logic [SEL_BITS-1:0]   rsp_idx;
  logic                  rsp_idx_ok;

  // A core may compete when it has a request and, for reads, a free credit.
  // Writes never consume credits, so they are never blocked by the limit.
  always_comb begin
    eligible  = '0;
    pend_zero = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      pend_zero[i] = (pend[i] == '0);
      eligible[i]  = in_req_valid[i] & (in_req_rw[i] | (pend[i] < CNT_W'(MAX_PENDING)));
    end
  end

  // Round-robin pick: scan from rr_ptr upward, wrapping at NUM_INPUTS, and
  // take the first eligible core. cand carries one extra bit so the sum
  // before wrapping cannot overflow.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 0; off < NUM_INPUTS; off++) begin
      cand = {1'b0, rr_ptr} + (SEL_BITS+1)'(off);
      if (cand >= (SEL_BITS+1)'(NUM_INPUTS)) begin
        cand = cand - (SEL_BITS+1)'(NUM_INPUTS);
      end
      if (!win_found && eligible[cand[SEL_BITS-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[SEL_BITS-1:0];
      end
    end
  end

  // The output register can take a new request when empty or draining.
  assign accept = win_found & (~out_req_valid | out_req_ready);

  // Response steering uses the index bits that were appended on issue.
  // Indices with no matching core are swallowed and flagged.
  assign rsp_idx    = rsp_tag[SEL_BITS-1:0];
  assign rsp_idx_ok = ({1'b0, rsp_idx} < (SEL_BITS+1)'(NUM_INPUTS));
  assign rsp_ready  = rsp_idx_ok ? in_rsp_ready[rsp_idx] : 1'b1;

  assign in_rsp_data = {NUM_INPUTS{rsp_data}};
  assign in_rsp_tag  = {NUM_INPUTS{rsp_tag[OTAG_W-1:SEL_BITS]}};

  // Per-core grant, response valid and credit up/down events.
  always_comb begin
    in_req_ready = '0;
    in_rsp_valid = '0;
    pend_inc     = '0;
    pend_dec     = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_req_ready[i] = accept & (win_idx == SEL_BITS'(i));
      in_rsp_valid[i] = rsp_valid & rsp_idx_ok & (rsp_idx == SEL_BITS'(i));
      pend_inc[i]     = in_req_ready[i] & ~in_req_rw[i];
      pend_dec[i]     = in_rsp_valid[i] & in_rsp_ready[i];
    end
  end

  // Output stage: capture the winner on accept; otherwise hold until the
  // cache takes it. The pointer moves past the winner only on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_req_valid <= 1'b0;
      out_req_rw    <= 1'b0;
      out_req_addr  <= '0;
      out_req_data  <= '0;
      out_req_tag   <= '0;
      rr_ptr        <= '0;
    end else if (accept) begin
      out_req_valid <= 1'b1;
      out_req_rw    <= in_req_rw[win_idx];
      out_req_addr  <= in_req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
      out_req_data  <= in_req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
      out_req_tag   <= {in_req_tag[win_idx*TAG_WIDTH +: TAG_WIDTH], win_idx};
      rr_ptr        <= (win_idx == SEL_BITS'(NUM_INPUTS-1)) ? '0 : win_idx + SEL_BITS'(1);
    end else if (out_req_ready) begin
      out_req_valid <= 1'b0;
    end
  end

  // Credit counters. A simultaneous issue and return cancel out. A return
  // to a core with nothing outstanding leaves the counter at zero and is
  // reported through rsp_err instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        pend[i] <= '0;
      end
      rsp_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (pend_inc[i] && !pend_dec[i]) begin
          pend[i] <= pend[i] + CNT_W'(1);
        end else if (pend_dec[i] && !pend_inc[i] && !pend_zero[i]) begin
          pend[i] <= pend[i] - CNT_W'(1);
        end
      end
      rsp_err <= rsp_err | (rsp_valid & ~rsp_idx_ok) | (|(pend_dec & pend_zero));
    end
  end

  assign busy = out_req_valid | ~(&pend_zero);

endmodule

// File: tb/tb_vx_socket_req_sched.sv
// ---------------------------------------------------------------------------
// tb_vx_socket_req_sched
//
// Drives vx_socket_req_sched with directed scenarios followed by random
// traffic, comparing every cycle against a behavioural model of the
// scheduler kept here (credit counts, rotating priority, held request).
// ---------------------------------------------------------------------------
module tb_vx_socket_req_sched;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TW   = 8;
  localparam int MAXP = 4;
  localparam int SB   = 2;
  localparam int OW   = TW + SB;

  logic clk = 1'b0;
  logic reset;

  logic [N-1:0]    in_req_valid;
  logic [N-1:0]    in_req_rw;
  logic [N*AW-1:0] in_req_addr;
  logic [N*DW-1:0] in_req_data;
  logic [N*TW-1:0] in_req_tag;
  logic [N-1:0]    in_req_ready;
  logic            out_req_valid;
  logic            out_req_rw;
  logic [AW-1:0]   out_req_addr;
  logic [DW-1:0]   out_req_data;
  logic [OW-1:0]   out_req_tag;
  logic            out_req_ready;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [OW-1:0]   rsp_tag;
  logic            rsp_ready;
  logic [N-1:0]    in_rsp_valid;
  logic [N*DW-1:0] in_rsp_data;
  logic [N*TW-1:0] in_rsp_tag;
  logic [N-1:0]    in_rsp_ready;
  logic            busy;
  logic            rsp_err;

  always #5 clk = ~clk;

  vx_socket_req_sched #(
    .NUM_INPUTS (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_req_valid (in_req_valid),
    .in_req_rw    (in_req_rw),
    .in_req_addr  (in_req_addr),
    .in_req_data  (in_req_data),
    .in_req_tag   (in_req_tag),
    .in_req_ready (in_req_ready),
    .out_req_valid(out_req_valid),
    .out_req_rw   (out_req_rw),
    .out_req_addr (out_req_addr),
    .out_req_data (out_req_data),
    .out_req_tag  (out_req_tag),
    .out_req_ready(out_req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_tag      (rsp_tag),
    .rsp_ready    (rsp_ready),
    .in_rsp_valid (in_rsp_valid),
    .in_rsp_data  (in_rsp_data),
    .in_rsp_tag   (in_rsp_tag),
    .in_rsp_ready (in_rsp_ready),
    .busy         (busy),
    .rsp_err      (rsp_err)
  );

  // Reference model state
  int            m_pend [N];
  int            m_rr;
  bit            m_valid;
  bit            m_rw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_tag;
  bit            m_err;

  int n_checks;
  int n_fail;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    m_rr    = 0;
    m_valid = 0;
    m_rw    = 0;
    m_addr  = '0;
    m_data  = '0;
    m_tag   = 0;
    m_err   = 0;
  endtask

  task automatic clearInputs();
    in_req_valid  = '0;
    in_req_rw     = '0;
    in_req_addr   = '0;
    in_req_data   = '0;
    in_req_tag    = '0;
    out_req_ready = 1'b1;
    rsp_valid     = 1'b0;
    rsp_data      = '0;
    rsp_tag       = '0;
    in_rsp_ready  = '0;
  endtask

  task automatic setReq(input int i, input bit v, input bit rw,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [TW-1:0] t);
    in_req_valid[i]         = v;
    in_req_rw[i]            = rw;
    in_req_addr[i*AW +: AW] = a;
    in_req_data[i*DW +: DW] = d;
    in_req_tag[i*TW +: TW]  = t;
  endtask

  task automatic setRsp(input bit v, input int core, input logic [TW-1:0] t,
                        input logic [DW-1:0] d, input logic [N-1:0] rdy);
    rsp_valid    = v;
    rsp_tag      = OW'(int'(t) * N + core);
    rsp_data     = d;
    in_rsp_ready = rdy;
  endtask

  // One clock: compare outputs to the model mid-cycle, then advance the
  // model at the rising edge using the same inputs.
  task automatic applyStimulus();
    int            w;
    int            c;
    int            idx;
    int            inc_core;
    bit            acc;
    bit            fire;
    bit            any_pend;
    logic [N-1:0]  exp_ready;
    logic [N-1:0]  exp_rvalid;
    logic [N*TW-1:0] exp_rtag;

    @(negedge clk);
    #1;
    any_pend = 0;
    for (int i = 0; i < N; i++) if (m_pend[i] != 0) any_pend = 1;
    checkOutput("out_req_valid", 64'(out_req_valid), 64'(m_valid));
    checkOutput("out_req_rw",    64'(out_req_rw),    64'(m_rw));
    checkOutput("out_req_addr",  64'(out_req_addr),  64'(m_addr));
    checkOutput("out_req_data",  64'(out_req_data),  64'(m_data));
    checkOutput("out_req_tag",   64'(out_req_tag),   64'(m_tag));
    checkOutput("busy",          64'(busy),          64'(m_valid || any_pend));
    checkOutput("rsp_err",       64'(rsp_err),       64'(m_err));

    w = -1;
    for (int k = 0; k < N; k++) begin
      c = (m_rr + k) % N;
      if (w < 0 && in_req_valid[c] && (in_req_rw[c] || m_pend[c] < MAXP)) w = c;
    end
    acc = (w >= 0) && (!m_valid || out_req_ready);
    exp_ready = '0;
    if (acc) exp_ready[w] = 1'b1;
    checkOutput("in_req_ready", 64'(in_req_ready), 64'(exp_ready));

    idx  = int'(rsp_tag) % N;
    fire = rsp_valid && in_rsp_ready[idx];
    exp_rvalid = '0;
    if (rsp_valid) exp_rvalid[idx] = 1'b1;
    for (int k = 0; k < N; k++) exp_rtag[k*TW +: TW] = TW'(int'(rsp_tag) / N);
    checkOutput("rsp_ready",    64'(rsp_ready),    64'(in_rsp_ready[idx]));
    checkOutput("in_rsp_valid", 64'(in_rsp_valid), 64'(exp_rvalid));
    checkOutput("in_rsp_tag",   64'(in_rsp_tag),   64'(exp_rtag));
    checkOutput("in_rsp_data",  64'(in_rsp_data[idx*DW +: DW]), 64'(rsp_data));

    @(posedge clk);
    inc_core = -1;
    if (acc) begin
      m_valid = 1;
      m_rw    = in_req_rw[w];
      m_addr  = in_req_addr[w*AW +: AW];
      m_data  = in_req_data[w*DW +: DW];
      m_tag   = int'(in_req_tag[w*TW +: TW]) * N + w;
      m_rr    = (w + 1) % N;
      if (!in_req_rw[w]) inc_core = w;
    end else if (out_req_ready) begin
      m_valid = 0;
    end
    for (int k = 0; k < N; k++) begin
      if (fire && k == idx && m_pend[k] == 0) m_err = 1;
      if (k == inc_core && !(fire && k == idx)) m_pend[k]++;
      else if (fire && k == idx && k != inc_core && m_pend[k] > 0) m_pend[k]--;
    end
    #1;
  endtask

  // Asynchronous reset pulse; outputs must clear before any clock edge.
  task automatic doReset();
    clearInputs();
    reset = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(out_req_valid), 64'(0));
    checkOutput("rst_busy",      64'(busy),          64'(0));
    checkOutput("rst_rsp_err",   64'(rsp_err),       64'(0));
    checkOutput("rst_out_tag",   64'(out_req_tag),   64'(0));
    checkOutput("rst_out_addr",  64'(out_req_addr),  64'(0));
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic randomResponse();
    int live [$];
    int pick;
    live.delete();
    for (int i = 0; i < N; i++) if (m_pend[i] > 0) live.push_back(i);
    if (live.size() == 0 || $urandom_range(0, 2) == 0) begin
      setRsp(0, 0, 8'h00, '0, N'($urandom));
    end else begin
      pick = live[$urandom_range(0, live.size() - 1)];
      setRsp(1, pick, TW'($urandom), DW'($urandom), N'($urandom));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clearInputs();
    modelReset();
    #1;
    doReset();

    // Cores 0 and 2 request reads together: 0 first, then 2.
    setReq(0, 1, 0, 32'h1000_0000, 32'h0, 8'h11);
    setReq(2, 1, 0, 32'h2000_0000, 32'h0, 8'h22);
    applyStimulus();
    applyStimulus();
    in_req_valid = '0;
    applyStimulus();
    applyStimulus();
    // Drain both reads.
    setRsp(1, 0, 8'h11, 32'hAAAA_0000, 4'b1111);
    applyStimulus();
    setRsp(1, 2, 8'h22, 32'hBBBB_0000, 4'b1111);
    applyStimulus();
    setRsp(0, 0, 8'h00, '0, '0);
    applyStimulus();

    // All four cores streaming writes: grants rotate 0,1,2,3,0.
    doReset();
    for (int i = 0; i < N; i++) setReq(i, 1, 1, AW'(32'h100 * i), DW'(32'hD0 + i), TW'(8'h40 + i));
    for (int k = 0; k < 5; k++) applyStimulus();
    // Backpressure for three cycles, then resume.
    out_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus();
    out_req_ready = 1'b1;
    for (int k = 0; k < 2; k++) applyStimulus();

    // Core 1 exhausts its read credits; a write still gets through.
    doReset();
    setReq(1, 1, 0, 32'h0000_1111, 32'h0, 8'h5A);
    for (int k = 0; k < 6; k++) applyStimulus();
    in_req_rw[1] = 1'b1;
    applyStimulus();
    in_req_valid = '0;
    applyStimulus();
    // Response to core 1 frees a credit.
    setRsp(1, 1, 8'h5A, 32'hCAFE_F00D, 4'b0010);
    applyStimulus();
    // Simultaneous read issue and response on core 1.
    setReq(1, 1, 0, 32'h0000_2222, 32'h0, 8'h5B);
    setRsp(1, 1, 8'h5A, 32'hCAFE_0001, 4'b0010);
    applyStimulus();
    setRsp(0, 0, 8'h00, '0, '0);
    for (int k = 0; k < 2; k++) applyStimulus();
    in_req_valid = '0;
    applyStimulus();

    // Response to idle core 3 raises a sticky error.
    setRsp(1, 3, 8'h77, 32'h0, 4'b1000);
    applyStimulus();
    setRsp(0, 0, 8'h00, '0, '0);
    for (int k = 0; k < 3; k++) applyStimulus();

    // Reset while a request is being held.
    doReset();
    out_req_ready = 1'b0;
    setReq(0, 1, 0, 32'hDEAD_BEEF, 32'h0, 8'h99);
    applyStimulus();
    applyStimulus();
    checkOutput("held_before_reset", 64'(out_req_valid), 64'(m_valid));
    doReset();
    applyStimulus();

    // Random traffic.
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        setReq(i, ($urandom_range(0, 99) < 60), ($urandom_range(0, 3) == 0),
               AW'($urandom), DW'($urandom), TW'($urandom));
      end
      out_req_ready = ($urandom_range(0, 3) != 0);
      randomResponse();
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
